crpa_args_packer: RTL and testbench

Serial-to-parallel front end for the CRPA pipelined adder tree. It collects `N_args` signed samples arriving one per valid cycle on a single lane-multiplexed stream and assembles them into one wide argument word. The word is zero-padded up to the next power-of-two lane count and issued with a one-cycle `we` strobe, matching what `piped_adder` expects on `args_in`/`we`. A frame-start marker keeps lane alignment, and the block detects and counts resynchronisation events.

---
 rtl/crpa_args_packer.sv | 78 +++++++
 tb/tb_crpa_args_packer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/crpa_args_packer.sv
// Serial-to-parallel argument packer for the CRPA adder tree: gathers N_args
// samples from one lane-multiplexed stream into a zero-padded wide word.
module crpa_args_packer #(
  parameter  int N_args    = 4,
  parameter  int arg_width = 14,
  localparam int NS2       = 2 ** $clog2(N_args),
  localparam int LW        = $clog2(N_args) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [arg_width-1:0]     din,
  input  logic                     din_valid,
  input  logic                     din_first,
  output logic [NS2*arg_width-1:0] args_out,
  output logic                     we,
  output logic [LW-1:0]            lane_idx,
  output logic                     err_sync,
  output logic [15:0]              err_cnt
);

  localparam logic [LW-1:0] LAST = LW'(N_args - 1);

  logic [arg_width-1:0]     shadow [N_args];
  logic [NS2*arg_width-1:0] frame;
  logic                     resync;

  assign resync = din_valid && din_first && (lane_idx != '0);

  // The lane being written this cycle takes din directly, so a completing
  // frame can be emitted on the same edge that accepts its last sample.
  always_comb begin
    frame = '0;
    for (int unsigned k = 0; k < N_args; k++) begin
      frame[k*arg_width +: arg_width] = (lane_idx == LW'(k)) ? din : shadow[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < N_args; k++) begin
        shadow[k] <= '0;
      end
      args_out <= '0;
      we       <= 1'b0;
      lane_idx <= '0;
      err_sync <= 1'b0;
      err_cnt  <= '0;
    end else begin
      we       <= 1'b0;
      err_sync <= 1'b0;
      if (din_valid) begin
        if (resync) begin
          // Partial frame is abandoned; din restarts the frame at lane 0.
          shadow[0] <= din;
          err_sync  <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + 16'd1;
          end
          lane_idx <= LW'(1);
        end else begin
          for (int unsigned k = 0; k < N_args; k++) begin
            if (lane_idx == LW'(k)) begin
              shadow[k] <= din;
            end
          end
          if (lane_idx == LAST) begin
            args_out <= frame;
            we       <= 1'b1;
            lane_idx <= '0;
          end else begin
            lane_idx <= lane_idx + LW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_crpa_args_packer.sv
// Directed bench for crpa_args_packer (N_args=3, arg_width=8) with a
// queue-based frame model checked every cycle plus literal expectations.
module tb_crpa_args_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_first = 1'b0;
  logic [31:0] args_out;
  logic        we;
  logic [2:0]  lane_idx;
  logic        err_sync;
  logic [15:0] err_cnt;

  crpa_args_packer #(.N_args(3), .arg_width(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_first(din_first), .args_out(args_out), .we(we),
    .lane_idx(lane_idx), .err_sync(err_sync), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int we_count = 0;
  int err_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Model: a frame is simply the list of samples accepted since it began.
  logic [7:0]  q[$];
  logic [31:0] m_args;
  logic        m_we, m_err, m_ok = 1'b0;
  logic [15:0] m_cnt;
  logic [2:0]  m_lane;

  always @(posedge clk) begin
    cycle++;
    if (!reset) begin
      q.delete();
      m_args = '0; m_we = 1'b0; m_err = 1'b0; m_cnt = '0; m_ok = 1'b1;
    end else begin
      m_we = 1'b0; m_err = 1'b0;
      if (din_valid) begin
        if (din_first && q.size() != 0) begin
          q.delete();
          m_err = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        q.push_back(din);
        if (q.size() == 3) begin
          m_args = {8'h00, q[2], q[1], q[0]};
          m_we = 1'b1;
          q.delete();
        end
      end
    end
    m_lane = 3'(q.size());
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("args_out", args_out, m_args);
      chk("we", 32'(we), 32'(m_we));
      chk("lane_idx", 32'(lane_idx), 32'(m_lane));
      chk("err_sync", 32'(err_sync), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (we) we_count++;
      if (err_sync) err_pulses++;
    end
  end

  task automatic cyc(input logic v, input logic f, input logic [7:0] d);
    din_valid = v; din_first = f; din = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  int base, t1, t2;

  initial begin
    // Reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 2; i++) cyc(1'($urandom), 1'($urandom), 8'($urandom));
    chk("rst_args", args_out, 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_lane", 32'(lane_idx), 32'h0);
    chk("rst_err", 32'({err_sync, err_cnt}), 32'h0);
    reset = 1'b1;

    // Basic frame
    cyc(1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    chk("basic_we", 32'(we), 32'h1);
    chk("basic_args", args_out, 32'h00332211);
    idle(1);
    chk("basic_we_drop", 32'(we), 32'h0);
    chk("basic_hold", args_out, 32'h00332211);

    // Gapped input
    cyc(1'b1, 1'b1, 8'h11); idle(2);
    cyc(1'b1, 1'b0, 8'h22); idle(2);
    cyc(1'b1, 1'b0, 8'h33);
    chk("gap_we", 32'(we), 32'h1);
    chk("gap_args", args_out, 32'h00332211);

    // Six back-to-back samples: strobes exactly 3 cycles apart
    t1 = -1; t2 = -1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, (i % 3) == 0, 8'(8'h40 + i));
      if (we) begin
        if (t1 < 0) t1 = cycle; else t2 = cycle;
      end
    end
    chk("b2b_spacing", 32'(t2 - t1), 32'd3);
    chk("b2b_args", args_out, 32'h00454443);

    // Resync
    base = we_count;
    cyc(1'b1, 1'b1, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    cyc(1'b1, 1'b1, 8'h7F);
    chk("resync_pulse", 32'(err_sync), 32'h1);
    chk("resync_cnt", 32'(err_cnt), 32'h1);
    chk("resync_lane", 32'(lane_idx), 32'h1);
    cyc(1'b1, 1'b0, 8'h80);
    chk("resync_pulse_drop", 32'(err_sync), 32'h0);
    cyc(1'b1, 1'b0, 8'h81);
    chk("resync_args", args_out, 32'h0081807F);
    chk("resync_frames", 32'(we_count - base), 32'h1);

    // Resync on the last-lane position: no strobe, pulse instead
    cyc(1'b1, 1'b1, 8'h21);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b1, 8'h23);
    chk("lastlane_we", 32'(we), 32'h0);
    chk("lastlane_pulse", 32'(err_sync), 32'h1);
    chk("lastlane_cnt", 32'(err_cnt), 32'h2);
    cyc(1'b1, 1'b0, 8'h24);
    cyc(1'b1, 1'b0, 8'h25);
    chk("lastlane_args", args_out, 32'h00252423);

    // Reset mid-frame
    cyc(1'b1, 1'b1, 8'hAA);
    cyc(1'b1, 1'b0, 8'hBB);
    base = err_pulses;
    reset = 1'b0;
    cyc(1'($urandom), 1'($urandom), 8'($urandom));
    reset = 1'b1;
    chk("midrst_cnt", 32'(err_cnt), 32'h0);
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    cyc(1'b1, 1'b0, 8'h03);
    chk("midrst_args", args_out, 32'h00030201);
    chk("midrst_no_err", 32'(err_pulses - base), 32'h0);

    // Saturation: every din_first after the first one is a resync
    cyc(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 65534; i++) cyc(1'b1, 1'b1, 8'(i));
    chk("sat_near", 32'(err_cnt), 32'h0000FFFE);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'(i));
    chk("sat_cnt", 32'(err_cnt), 32'h0000FFFF);
    chk("sat_pulse", 32'(err_sync), 32'h1);
    idle(2);
    chk("sat_hold", 32'(err_cnt), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
